// File: rtl/time_display_scan.sv
// Six-digit multiplexed HH.MM.SS display driver on the timekeeper's time bus.
// Takes one snapshot of the time per scan frame and converts it to BCD with a subtract-10 engine.
module time_display_scan #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 6000,
  parameter int BLINK_HZ = 2
) (
  input  logic       Clk_50Mhz,
  input  logic       Rst_n,
  input  logic [5:0] SecTk,
  input  logic [5:0] MinTk,
  input  logic [4:0] HrTk,
  input  logic [1:0] Edit,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [5:0] An,
  output logic       FrameSync
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [3:0] DASH = 4'hF;

  typedef enum logic [2:0] {IDLE, CAPTURE, CONV_S, CONV_M, CONV_H, LOAD} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] scan_cnt;
  logic          scan_tick;
  logic [2:0]    digit_idx;
  logic          first_tick;
  logic          frame_start;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          blank;

  logic [5:0]    snap_sec;
  logic [5:0]    snap_min;
  logic [4:0]    snap_hr;
  logic [5:0]    work;
  logic [2:0]    tens;
  logic          work_ge10;
  logic          field_ok;
  logic [3:0]    ones_dig;
  logic [3:0]    tens_dig;
  logic [3:0]    stage [6];
  logic [3:0]    disp  [6];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = 7'h3F;
    endcase
  endfunction

  assign scan_tick   = (scan_cnt == SW'(SCAN_DIV - 1));
  // A new frame begins when the scan wraps back to digit 0, or on the very first tick.
  assign frame_start = scan_tick && ((digit_idx == 3'd5) || first_tick);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      scan_cnt   <= '0;
      digit_idx  <= '0;
      first_tick <= 1'b1;
    end else if (scan_tick) begin
      scan_cnt   <= '0;
      digit_idx  <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
      first_tick <= 1'b0;
    end else begin
      scan_cnt   <= scan_cnt + SW'(1);
    end
  end

  always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign work_ge10 = (work >= 6'd10);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = CAPTURE;
      CAPTURE: state_nxt = CONV_S;
      CONV_S:  if (!work_ge10) state_nxt = CONV_M;
      CONV_M:  if (!work_ge10) state_nxt = CONV_H;
      CONV_H:  if (!work_ge10) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    field_ok = 1'b1;
    case (state)
      CONV_S:  field_ok = (snap_sec <= 6'd59);
      CONV_M:  field_ok = (snap_min <= 6'd59);
      CONV_H:  field_ok = (snap_hr  <= 5'd23);
      default: field_ok = 1'b1;
    endcase
  end

  assign ones_dig = field_ok ? work[3:0]     : DASH;
  assign tens_dig = field_ok ? {1'b0, tens}  : DASH;

  // NOTE: the digit arrays are reset explicitly because their reset contents are shown on the display.
  always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hr   <= '0;
      work      <= '0;
      tens      <= '0;
      stage     <= '{default: 4'd0};
      disp      <= '{default: 4'd0};
      FrameSync <= 1'b0;
    end else begin
      FrameSync <= 1'b0;
      case (state)
        CAPTURE: begin
          snap_sec <= SecTk;
          snap_min <= MinTk;
          snap_hr  <= HrTk;
          work     <= SecTk;
          tens     <= '0;
        end
        CONV_S: begin
          if (work_ge10) begin
            work <= work - 6'd10;
            tens <= tens + 3'd1;
          end else begin
            stage[0] <= ones_dig;
            stage[1] <= tens_dig;
            work     <= snap_min;
            tens     <= '0;
          end
        end
        CONV_M: begin
          if (work_ge10) begin
            work <= work - 6'd10;
            tens <= tens + 3'd1;
          end else begin
            stage[2] <= ones_dig;
            stage[3] <= tens_dig;
            work     <= {1'b0, snap_hr};
            tens     <= '0;
          end
        end
        CONV_H: begin
          if (work_ge10) begin
            work <= work - 6'd10;
            tens <= tens + 3'd1;
          end else begin
            stage[4] <= ones_dig;
            stage[5] <= tens_dig;
          end
        end
        LOAD: begin
          disp      <= stage;
          FrameSync <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Digit pairs map to Edit fields 1 (sec), 2 (min), 3 (hr).
  assign blank = !blink_phase && (Edit == (digit_idx[2:1] + 2'd1));

  always_ff @(posedge Clk_50Mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      An  <= 6'h3F;
      Seg <= 7'h7F;
      Dp  <= 1'b1;
    end else if (scan_tick) begin
      An  <= blank ? 6'h3F : ~(6'd1 << digit_idx);
      Seg <= seg_of(disp[digit_idx]);
      Dp  <= !((digit_idx == 3'd2) || (digit_idx == 3'd4));
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Self-checking bench for time_display_scan: arithmetic reference model plus literal spot checks.
module tb_time_display_scan;

  localparam int SCAN_DIV  = 64;
  localparam int BLINK_DIV = 320;
  localparam int FS_WINDOW = 24;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic [5:0] sec_tk = '0;
  logic [5:0] min_tk = '0;
  logic [4:0] hr_tk  = '0;
  logic [1:0] edit   = '0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_sync;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  time_display_scan #(
    .CLK_HZ  (64000),
    .SCAN_HZ (1000),
    .BLINK_HZ(100)
  ) dut (
    .Clk_50Mhz(clk),
    .Rst_n    (rst_n),
    .SecTk    (sec_tk),
    .MinTk    (min_tk),
    .HrTk     (hr_tk),
    .Edit     (edit),
    .Seg      (seg),
    .Dp       (dp),
    .An       (an),
    .FrameSync(frame_sync)
  );

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input int v);
    if (v < 0) return 7'h3F;
    return seg_tab[v];
  endfunction

  // Reference model: time in cycles since reset release, digits from / and %.
  int         m_cyc;
  int         m_ticks;
  bit         m_cap_next;
  int         m_disp [6];
  logic [5:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;
  bit         m_tick_now;
  bit         m_frame_started;
  int         m_digit;
  bit         m_phase_at_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0;
      m_ticks = 0;
      m_cap_next = 1'b0;
      m_disp = '{default: 0};
      m_an = 6'h3F;
      m_seg = 7'h7F;
      m_dp = 1'b1;
      m_tick_now = 1'b0;
      m_frame_started = 1'b0;
      m_digit = -1;
      m_phase_at_tick = 1'b1;
    end else begin : model_edge
      bit phase;
      int d;
      m_tick_now = 1'b0;
      m_frame_started = 1'b0;
      phase = ((m_cyc / BLINK_DIV) % 2) == 0;
      if (m_cap_next) begin
        m_disp[0] = (sec_tk > 59) ? -1 : int'(sec_tk) % 10;
        m_disp[1] = (sec_tk > 59) ? -1 : int'(sec_tk) / 10;
        m_disp[2] = (min_tk > 59) ? -1 : int'(min_tk) % 10;
        m_disp[3] = (min_tk > 59) ? -1 : int'(min_tk) / 10;
        m_disp[4] = (hr_tk > 23)  ? -1 : int'(hr_tk) % 10;
        m_disp[5] = (hr_tk > 23)  ? -1 : int'(hr_tk) / 10;
        m_cap_next = 1'b0;
      end
      if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
        d = m_ticks % 6;
        m_an = 6'h3F;
        if (!(!phase && edit != 0 && int'(edit) == d / 2 + 1)) m_an[d] = 1'b0;
        m_seg = enc(m_disp[d]);
        m_dp = !(d == 2 || d == 4);
        if (d == 5 || m_ticks == 0) begin
          m_cap_next = 1'b1;
          m_frame_started = 1'b1;
        end
        m_ticks++;
        m_tick_now = 1'b1;
        m_digit = d;
        m_phase_at_tick = phase;
      end
      m_cyc++;
    end
  end

  // Compare process: outputs every cycle, FrameSync exactly once within each frame window.
  int fs_win = 0;
  bit fs_seen = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      check("outputs", {an, seg, dp}, {m_an, m_seg, m_dp});
      if (!rst_n) begin
        fs_win = 0;
        check("frame_sync_in_reset", frame_sync, 1'b0);
      end else begin
        if (m_frame_started) begin
          fs_win = FS_WINDOW;
          fs_seen = 1'b0;
        end
        if (fs_win > 0) begin
          if (frame_sync) begin
            check("frame_sync_single", fs_seen, 1'b0);
            fs_seen = 1'b1;
          end
          fs_win--;
          if (fs_win == 0) check("frame_sync_within_window", fs_seen, 1'b1);
        end else begin
          check("frame_sync_idle", frame_sync, 1'b0);
        end
      end
    end
  end

  // Wait for the next scan tick showing digit d (any digit if d < 0), bounded.
  task automatic wait_digit(input int d);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 2000) begin
      @(negedge clk);
      n++;
      hit = m_tick_now && (d < 0 || m_digit == d);
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_digit_%0d: no tick after %0d cycles, required within 2000", d, n);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hr_tk  = 5'(h);
    min_tk = 6'(m);
    sec_tk = 6'(s);
  endtask

  logic [6:0] exp_seg [6];
  logic [5:0] exp_an  [6];

  initial begin
    exp_an = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

    // Reset and blank period before the first scan tick.
    #1 rst_n = 1'b0;
    started = 1'b1;
    set_time(12, 34, 56);
    edit = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {an, seg, dp, frame_sync}, {6'h3F, 7'h7F, 1'b1, 1'b0});
    rst_n = 1'b1;
    repeat (63) @(negedge clk);
    check("blank_before_first_tick", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
    wait_digit(0);
    check("first_tick_digit0_zero", {an, seg}, {6'h3E, 7'h40});

    // One full frame of 12:34:56.
    exp_seg = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    wait_digit(5);
    for (int d = 0; d < 6; d++) begin
      wait_digit(d);
      check($sformatf("frame_seg_d%0d", d), seg, exp_seg[d]);
      check($sformatf("frame_an_d%0d", d), an, exp_an[d]);
      check($sformatf("frame_dp_d%0d", d), dp, (d == 2 || d == 4) ? 1'b0 : 1'b1);
    end

    // Mid-frame change is held off until the next frame.
    wait_digit(2);
    sec_tk = 6'd57;
    wait_digit(3);
    check("tear_d3", seg, 7'h30);
    wait_digit(4);
    check("tear_d4", seg, 7'h24);
    wait_digit(5);
    check("tear_d5", seg, 7'h79);
    wait_digit(0);
    check("next_frame_sec_ones", seg, 7'h78);
    wait_digit(1);
    check("next_frame_sec_tens", seg, 7'h12);

    // Out-of-range hours and minutes become dashes.
    hr_tk  = 5'd25;
    min_tk = 6'd60;
    exp_seg = '{7'h78, 7'h12, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    wait_digit(5);
    for (int d = 0; d < 6; d++) begin
      wait_digit(d);
      check($sformatf("range_seg_d%0d", d), seg, exp_seg[d]);
    end

    // Minute field blinks while Edit = 2.
    set_time(12, 34, 56);
    edit = 2'd2;
    for (int i = 0; i < 60; i++) begin
      wait_digit(-1);
      if ((m_digit == 2 || m_digit == 3) && !m_phase_at_tick)
        check($sformatf("blink_blank_d%0d", m_digit), an, 6'h3F);
      else if (m_digit == 2 && m_phase_at_tick)
        check("blink_visible_d2", an, 6'h3B);
    end

    // Reset in the middle of the minute conversion.
    edit = 2'd0;
    wait_digit(5);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {an, seg, dp, frame_sync}, {6'h3F, 7'h7F, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (63) @(negedge clk);
    check("blank_after_abort", an, 6'h3F);
    wait_digit(0);
    check("display_cleared_by_reset", seg, 7'h40);

    // Randomized inputs, Edit and occasional resets, checked by the model.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(5, 150)) @(negedge clk);
      sec_tk = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
      min_tk = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
      hr_tk  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      edit   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        #($urandom_range(1, 8)) rst_n = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    repeat (40) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
